// File: rtl/ahb_sram_arbiter.sv
// Round-robin AHB arbiter and address/write-data mux sharing one SRAM slave port
// between N_MST masters, with burst protection, locked transfers and data-phase tracking.
module ahb_sram_arbiter #(
  parameter int unsigned N_MST         = 2,
  parameter int unsigned HADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned HMASTER_WIDTH = 8
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic [N_MST-1:0]              hbusreq,
  input  logic [N_MST-1:0]              hlock,
  input  logic [N_MST*HADDR_WIDTH-1:0]  m_haddr,
  input  logic [N_MST*2-1:0]            m_htrans,
  input  logic [N_MST-1:0]              m_hwrite,
  input  logic [N_MST*3-1:0]            m_hsize,
  input  logic [N_MST*3-1:0]            m_hburst,
  input  logic [N_MST*DATA_WIDTH-1:0]   m_hwdata,
  input  logic [N_MST*DATA_WIDTH/8-1:0] m_hwstrb,
  input  logic                          hready,
  input  logic                          hresp,
  output logic [N_MST-1:0]              hgrant,
  output logic [HMASTER_WIDTH-1:0]      hmaster,
  output logic                          hmasterlock,
  output logic [HADDR_WIDTH-1:0]        s_haddr,
  output logic [1:0]                    s_htrans,
  output logic                          s_hwrite,
  output logic [2:0]                    s_hsize,
  output logic [2:0]                    s_hburst,
  output logic [DATA_WIDTH-1:0]         s_hwdata,
  output logic [DATA_WIDTH/8-1:0]       s_hwstrb
);

  localparam int unsigned PTR_W = (N_MST > 1) ? $clog2(N_MST) : 1;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] hmaster_q, hmaster_d;
  logic [PTR_W-1:0] data_owner_q, data_owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hmasterlock_q, hmasterlock_d;
  logic             lock_hold_q, lock_hold_d;
  logic [3:0]       burst_left_q, burst_left_d;

  htrans_e          own_trans;
  logic [2:0]       own_burst;
  logic             own_lock;
  logic             grant_lock;
  logic [3:0]       burst_load;
  logic             rearb_ok;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [31:0]      rr_ext;

  // Attributes of the address-phase owner and of the current grantee
  always_comb begin
    own_trans  = TR_IDLE;
    own_burst  = '0;
    own_lock   = 1'b0;
    grant_lock = 1'b0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (hmaster_q == PTR_W'(i)) begin
        own_trans = htrans_e'(m_htrans[2*i +: 2]);
        own_burst = m_hburst[3*i +: 3];
        own_lock  = hlock[i];
      end
      if (gidx_q == PTR_W'(i)) grant_lock = hlock[i];
    end
  end

  always_comb begin
    case (own_burst)
      3'd2, 3'd3: burst_load = 4'd3;
      3'd4, 3'd5: burst_load = 4'd7;
      3'd6, 3'd7: burst_load = 4'd15;
      default:    burst_load = 4'd0;
    endcase
  end

  // An error response abandons the burst even while the slave is still stalling
  always_comb begin
    burst_left_d = burst_left_q;
    if (hresp) begin
      burst_left_d = '0;
    end else if (hready) begin
      case (own_trans)
        TR_NONSEQ: burst_left_d = burst_load;
        TR_SEQ:    burst_left_d = (burst_left_q != 4'd0) ? burst_left_q - 4'd1 : 4'd0;
        default:   burst_left_d = burst_left_q;
      endcase
    end
  end

  always_comb begin
    lock_hold_d = lock_hold_q;
    if (hready && own_trans == TR_NONSEQ && own_lock) begin
      lock_hold_d = 1'b1;
    end else if (hready && own_trans == TR_IDLE && !own_lock) begin
      lock_hold_d = 1'b0;
    end
  end

  // Next-cycle lock state gates rearbitration so the edge accepting a locked NONSEQ keeps the grant
  assign rearb_ok = hready && !lock_hold_d &&
                    ((burst_left_d == 4'd0) || (own_trans == TR_IDLE));

  // Search order starts just after the last winner, wrapping modulo N_MST
  assign rr_ext = 32'(rr_ptr_q);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N_MST; k++) begin
      for (int unsigned i = 0; i < N_MST; i++) begin
        if (!win_found && hbusreq[i] && (((rr_ext + k) % N_MST) == i)) begin
          win_found = 1'b1;
          win_idx   = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    hmaster_d     = hmaster_q;
    hmasterlock_d = hmasterlock_q;
    data_owner_d  = data_owner_q;
    if (rearb_ok) begin
      if (win_found) begin
        gidx_d   = win_idx;
        rr_ptr_d = win_idx;
      end else begin
        gidx_d = '0;
      end
    end
    if (hready) begin
      hmaster_d     = gidx_q;
      hmasterlock_d = grant_lock;
      data_owner_d  = hmaster_q;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      gidx_q        <= '0;
      hmaster_q     <= '0;
      data_owner_q  <= '0;
      rr_ptr_q      <= '0;
      hmasterlock_q <= 1'b0;
      lock_hold_q   <= 1'b0;
      burst_left_q  <= '0;
    end else begin
      gidx_q        <= gidx_d;
      hmaster_q     <= hmaster_d;
      data_owner_q  <= data_owner_d;
      rr_ptr_q      <= rr_ptr_d;
      hmasterlock_q <= hmasterlock_d;
      lock_hold_q   <= lock_hold_d;
      burst_left_q  <= burst_left_d;
    end
  end

  always_comb begin
    hgrant = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      hgrant[i] = (gidx_q == PTR_W'(i));
    end
  end

  assign hmaster     = HMASTER_WIDTH'(hmaster_q);
  assign hmasterlock = hmasterlock_q;

  // Address phase follows hmaster, write data follows the data-phase owner
  always_comb begin
    s_haddr  = '0;
    s_htrans = '0;
    s_hwrite = 1'b0;
    s_hsize  = '0;
    s_hburst = '0;
    s_hwdata = '0;
    s_hwstrb = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (hmaster_q == PTR_W'(i)) begin
        s_haddr  = m_haddr[HADDR_WIDTH*i +: HADDR_WIDTH];
        s_htrans = m_htrans[2*i +: 2];
        s_hwrite = m_hwrite[i];
        s_hsize  = m_hsize[3*i +: 3];
        s_hburst = m_hburst[3*i +: 3];
      end
      if (data_owner_q == PTR_W'(i)) begin
        s_hwdata = m_hwdata[DATA_WIDTH*i +: DATA_WIDTH];
        s_hwstrb = m_hwstrb[(DATA_WIDTH/8)*i +: (DATA_WIDTH/8)];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Bench for ahb_sram_arbiter with two masters: per-cycle vector table through a
// scoreboard queue, plus hand-written latency and combinational-mux sequences.
module tb_ahb_sram_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned HW = 8;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic [N-1:0]      hbusreq, hlock, m_hwrite;
  logic [N*AW-1:0]   m_haddr;
  logic [N*2-1:0]    m_htrans;
  logic [N*3-1:0]    m_hsize, m_hburst;
  logic [N*DW-1:0]   m_hwdata;
  logic [N*DW/8-1:0] m_hwstrb;
  logic              hready, hresp;
  logic [N-1:0]      hgrant;
  logic [HW-1:0]     hmaster;
  logic              hmasterlock;
  logic [AW-1:0]     s_haddr;
  logic [1:0]        s_htrans;
  logic              s_hwrite;
  logic [2:0]        s_hsize, s_hburst;
  logic [DW-1:0]     s_hwdata;
  logic [DW/8-1:0]   s_hwstrb;

  always #5 hclk = ~hclk;

  ahb_sram_arbiter #(.N_MST(N), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .HMASTER_WIDTH(HW)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hwstrb(m_hwstrb),
    .hready(hready), .hresp(hresp), .hgrant(hgrant), .hmaster(hmaster),
    .hmasterlock(hmasterlock), .s_haddr(s_haddr), .s_htrans(s_htrans),
    .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hwdata(s_hwdata), .s_hwstrb(s_hwstrb)
  );

  typedef struct {
    string      nm;
    logic       rst;
    logic [1:0] req, lck, tr0, tr1;
    logic [2:0] bu0, bu1;
    logic       rdy, rsp;
    logic [1:0] eg;
    logic       ehm, edo, eml;
    logic [3:0] ebl;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [AW-1:0]   ad [2];
  logic [DW-1:0]   wd [2];
  logic [DW/8-1:0] st [2];

  function automatic vec_t mk(input string nm, input logic rst, input logic [1:0] req,
                              input logic [1:0] lck, input logic [1:0] tr0, input logic [1:0] tr1,
                              input logic [2:0] bu0, input logic [2:0] bu1, input logic rdy,
                              input logic rsp, input logic [1:0] eg, input logic ehm,
                              input logic edo, input logic eml, input logic [3:0] ebl,
                              input logic err);
    vec_t v;
    v.nm = nm; v.rst = rst; v.req = req; v.lck = lck; v.tr0 = tr0; v.tr1 = tr1;
    v.bu0 = bu0; v.bu1 = bu1; v.rdy = rdy; v.rsp = rsp; v.eg = eg; v.ehm = ehm;
    v.edo = edo; v.eml = eml; v.ebl = ebl; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    hresetn  = v.rst;
    hbusreq  = v.req;
    hlock    = v.lck;
    m_htrans = {v.tr1, v.tr0};
    m_hburst = {v.bu1, v.bu0};
    hready   = v.rdy;
    hresp    = v.rsp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   cnt;

    ad[0] = 32'h1000_0010; ad[1] = 32'h2000_0040;
    wd[0] = {4{32'h0000_0A0A}}; wd[1] = {4{32'h0000_B1B1}};
    st[0] = 16'h00FF; st[1] = 16'hF0F0;
    m_haddr  = {ad[1], ad[0]};
    m_hwdata = {wd[1], wd[0]};
    m_hwstrb = {st[1], st[0]};
    m_hwrite = 2'b10;
    m_hsize  = {3'd4, 3'd2};

    //                 rst req    lock   tr0 tr1 bu0      bu1       rdy rsp grant hm do ml bl rr
    vecs.push_back(mk("rst0",  0, 2'b00, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rst1",  0, 2'b00, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle",  1, 2'b00, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 0, 0));
    vecs.push_back(mk("req1a", 1, 2'b10, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 0, 0, 0, 0, 1));
    vecs.push_back(mk("req1b", 1, 2'b10, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 1, 0, 0, 0, 1));
    vecs.push_back(mk("req1ns",1, 2'b10, 2'b00, ID, NS, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 1, 1, 0, 0, 1));
    vecs.push_back(mk("rel1",  1, 2'b00, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 1, 1, 0, 0, 1));
    vecs.push_back(mk("park1", 1, 2'b00, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 0, 1, 0, 0, 1));
    vecs.push_back(mk("park2", 1, 2'b00, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 0, 1));
    vecs.push_back(mk("b4ns",  1, 2'b01, 2'b00, NS, ID, B_INCR4,  B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 3, 1));
    vecs.push_back(mk("b4s2",  1, 2'b11, 2'b00, SQ, ID, B_INCR4,  B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 2, 1));
    vecs.push_back(mk("b4s3",  1, 2'b11, 2'b00, SQ, ID, B_INCR4,  B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 1, 1));
    vecs.push_back(mk("b4s4",  1, 2'b10, 2'b00, SQ, ID, B_INCR4,  B_SINGLE, 1, 0, 2'b10, 0, 0, 0, 0, 1));
    vecs.push_back(mk("b4hand",1, 2'b10, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 1, 0, 0, 0, 1));
    vecs.push_back(mk("rr0",   1, 2'b11, 2'b00, ID, NS, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 1, 1, 0, 0, 0));
    vecs.push_back(mk("rr1",   1, 2'b11, 2'b00, NS, NS, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 0, 1, 0, 0, 1));
    vecs.push_back(mk("rr2",   1, 2'b11, 2'b00, NS, NS, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rr3",   1, 2'b11, 2'b00, NS, NS, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 0, 1, 0, 0, 1));
    vecs.push_back(mk("lkg",   1, 2'b10, 2'b10, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 1, 0, 1, 0, 1));
    vecs.push_back(mk("lkns",  1, 2'b11, 2'b10, ID, NS, B_SINGLE, B_INCR,   1, 0, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk("lks1",  1, 2'b11, 2'b10, ID, SQ, B_SINGLE, B_INCR,   1, 0, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk("lks2",  1, 2'b11, 2'b10, ID, SQ, B_SINGLE, B_INCR,   1, 0, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk("lkrel", 1, 2'b11, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 1, 1, 0, 0, 0));
    vecs.push_back(mk("lkpost",1, 2'b01, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 0, 1, 0, 0, 0));
    vecs.push_back(mk("b8ns",  1, 2'b01, 2'b00, NS, ID, B_INCR8,  B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 7, 0));
    vecs.push_back(mk("b8s1",  1, 2'b11, 2'b00, SQ, ID, B_INCR8,  B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 6, 0));
    vecs.push_back(mk("wait1", 1, 2'b11, 2'b00, SQ, ID, B_INCR8,  B_SINGLE, 0, 0, 2'b01, 0, 0, 0, 6, 0));
    vecs.push_back(mk("wait2", 1, 2'b11, 2'b00, SQ, ID, B_INCR8,  B_SINGLE, 0, 0, 2'b01, 0, 0, 0, 6, 0));
    vecs.push_back(mk("wait3", 1, 2'b11, 2'b00, SQ, ID, B_INCR8,  B_SINGLE, 0, 0, 2'b01, 0, 0, 0, 6, 0));
    vecs.push_back(mk("err1",  1, 2'b11, 2'b00, SQ, ID, B_INCR8,  B_SINGLE, 0, 1, 2'b01, 0, 0, 0, 0, 0));
    vecs.push_back(mk("err2",  1, 2'b11, 2'b00, SQ, ID, B_INCR8,  B_SINGLE, 1, 1, 2'b10, 0, 0, 0, 0, 1));
    vecs.push_back(mk("epost", 1, 2'b10, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 1, 0, 0, 0, 1));
    vecs.push_back(mk("frz",   1, 2'b01, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 0, 0, 2'b10, 1, 0, 0, 0, 1));
    vecs.push_back(mk("unfrz", 1, 2'b01, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 1, 1, 0, 0, 0));
    vecs.push_back(mk("g1a",   1, 2'b10, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 0, 1, 0, 0, 1));
    vecs.push_back(mk("g1b",   1, 2'b10, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b10, 1, 0, 0, 0, 1));
    vecs.push_back(mk("b16ns", 1, 2'b10, 2'b00, ID, NS, B_SINGLE, B_INCR16, 1, 0, 2'b10, 1, 1, 0, 15, 1));
    vecs.push_back(mk("b16s1", 1, 2'b10, 2'b00, ID, SQ, B_SINGLE, B_INCR16, 1, 0, 2'b10, 1, 1, 0, 14, 1));
    vecs.push_back(mk("rstmid",0, 2'b10, 2'b00, ID, SQ, B_SINGLE, B_INCR16, 1, 0, 2'b01, 0, 0, 0, 0, 0));
    vecs.push_back(mk("after", 1, 2'b00, 2'b00, ID, ID, B_SINGLE, B_SINGLE, 1, 0, 2'b01, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      apply(vecs[k]);
      sb.push_back(vecs[k]);
      @(posedge hclk);
      #1;
      e = sb.pop_front();
      chk({e.nm, ".hgrant"},      hgrant,            e.eg);
      chk({e.nm, ".hmaster"},     hmaster,           {7'b0, e.ehm});
      chk({e.nm, ".hmasterlock"}, hmasterlock,       e.eml);
      chk({e.nm, ".s_haddr"},     s_haddr,           ad[e.ehm]);
      chk({e.nm, ".s_htrans"},    s_htrans,          e.ehm ? e.tr1 : e.tr0);
      chk({e.nm, ".s_hwdata"},    s_hwdata,          wd[e.edo]);
      chk({e.nm, ".s_hwstrb"},    s_hwstrb,          st[e.edo]);
      chk({e.nm, ".burst_left"},  dut.burst_left_q,  e.ebl);
      chk({e.nm, ".rr_ptr"},      dut.rr_ptr_q,      e.err);
    end

    // Grant latency from an idle, parked bus: two edges until master 1 owns the address phase
    hbusreq = 2'b10;
    cnt = 0;
    while (hmaster !== 8'd1 && cnt < 16) begin
      @(posedge hclk);
      #1;
      cnt++;
    end
    chk("latency.edges", cnt, 2);

    // Address-phase mux follows new master inputs with no clock
    m_haddr = {$urandom, $urandom};
    #1;
    chk("comb.s_haddr",  s_haddr,  m_haddr[63:32]);
    chk("comb.s_hwrite", s_hwrite, 1'b1);
    chk("comb.s_hsize",  s_hsize,  3'd4);
    @(posedge hclk);
    #1;
    chk("dphase.s_hwdata", s_hwdata, wd[1]);
    chk("dphase.s_hwstrb", s_hwstrb, st[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
